// File: rtl/trap_ctrl.sv
// trap_ctrl: M-mode trap/mret sequencer (squash, drain, CSR writes, redirect).
// Build option: define TRAP_VECTORED_EN for vectored interrupt targets.
package trap_pkg;
  localparam int XDEF = 64;

  typedef logic [11:0] csrIdx_t;

  typedef struct packed {
    logic [15:0]     cause;
    logic [XDEF-1:0] epc;
    logic [XDEF-1:0] tval;
  } trapInfo_t;
endpackage

module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN = XDEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_trap_vld,
  output logic            o_trap_rdy,
  input  trapInfo_t       i_trap_info,
  input  logic            i_trap_is_intr,
  input  logic            i_mret_vld,
  output logic            o_mret_rdy,
  output logic            o_flush,
  input  logic            i_flush_done,
  output logic            o_csr_we,
  output csrIdx_t         o_csr_widx,
  output logic [XLEN-1:0] o_csr_wdata,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  input  logic [XLEN-1:0] i_mstatus,
  output logic            o_redirect_vld,
  output logic [XLEN-1:0] o_redirect_pc,
  input  logic            i_redirect_rdy,
  output logic            o_busy
);

  localparam csrIdx_t CSR_MSTATUS = 12'h300;
  localparam csrIdx_t CSR_MEPC    = 12'h341;
  localparam csrIdx_t CSR_MCAUSE  = 12'h342;
  localparam csrIdx_t CSR_MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_DRAIN,
    S_WR_EPC,
    S_WR_CAUSE,
    S_WR_TVAL,
    S_WR_STATUS,
    S_REDIRECT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  trapInfo_t       r_info;
  logic            r_intr;
  logic            r_mret;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_target;

  logic            w_acc_trap;
  logic            w_acc_mret;
  logic            w_vec;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_off;
  logic [XLEN-1:0] w_trap_tgt;
  logic [XLEN-1:0] w_ms_trap;
  logic [XLEN-1:0] w_ms_mret;
  logic            w_unused;

  assign o_trap_rdy = (r_state == S_IDLE);
  assign o_mret_rdy = (r_state == S_IDLE) & ~i_trap_vld;
  assign o_busy     = (r_state != S_IDLE);
  assign o_redirect_pc = r_target;

  assign w_acc_trap = o_trap_rdy & i_trap_vld;
  assign w_acc_mret = o_mret_rdy & i_mret_vld;

  assign w_base = {i_mtvec[XLEN-1:2], 2'b00};
  assign w_off  = {{(XLEN-18){1'b0}}, r_info.cause, 2'b00};

`ifdef TRAP_VECTORED_EN
  assign w_vec    = r_intr & (i_mtvec[1:0] == 2'b01);
  assign w_unused = ^{i_mepc[0], r_info.epc[0]};
`else
  assign w_vec    = 1'b0;
  assign w_unused = ^{i_mepc[0], r_info.epc[0], i_mtvec[1:0]};
`endif

  assign w_trap_tgt = w_vec ? (w_base + w_off) : w_base;

  always_comb begin
    w_ms_trap          = i_mstatus;
    w_ms_trap[7]       = i_mstatus[3];
    w_ms_trap[3]       = 1'b0;
    w_ms_trap[12:11]   = 2'b11;
    w_ms_mret          = i_mstatus;
    w_ms_mret[3]       = i_mstatus[7];
    w_ms_mret[7]       = 1'b1;
    w_ms_mret[12:11]   = 2'b11;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc_trap || w_acc_mret)
          w_next = S_FLUSH;
      end
      S_FLUSH:     w_next = S_DRAIN;
      S_DRAIN: begin
        if (i_flush_done)
          w_next = r_mret ? S_WR_STATUS : S_WR_EPC;
      end
      S_WR_EPC:    w_next = S_WR_CAUSE;
      S_WR_CAUSE:  w_next = S_WR_TVAL;
      S_WR_TVAL:   w_next = S_WR_STATUS;
      S_WR_STATUS: w_next = S_REDIRECT;
      S_REDIRECT: begin
        if (i_redirect_rdy)
          w_next = S_IDLE;
      end
      default:     w_next = S_IDLE;
    endcase
  end

  // Outputs decode the state register only; the record was latched at accept.
  always_comb begin
    o_flush        = 1'b0;
    o_csr_we       = 1'b0;
    o_csr_widx     = '0;
    o_csr_wdata    = '0;
    o_redirect_vld = 1'b0;
    unique case (1'b1)
      r_state == S_FLUSH: o_flush = 1'b1;
      r_state == S_WR_EPC: begin
        o_csr_we    = 1'b1;
        o_csr_widx  = CSR_MEPC;
        o_csr_wdata = {r_info.epc[XLEN-1:1], 1'b0};
      end
      r_state == S_WR_CAUSE: begin
        o_csr_we    = 1'b1;
        o_csr_widx  = CSR_MCAUSE;
        o_csr_wdata = {r_intr, {(XLEN-17){1'b0}}, r_info.cause};
      end
      r_state == S_WR_TVAL: begin
        o_csr_we    = 1'b1;
        o_csr_widx  = CSR_MTVAL;
        o_csr_wdata = r_intr ? '0 : r_info.tval;
      end
      r_state == S_WR_STATUS: begin
        o_csr_we    = 1'b1;
        o_csr_widx  = CSR_MSTATUS;
        o_csr_wdata = r_mret ? w_ms_mret : w_ms_trap;
      end
      r_state == S_REDIRECT: o_redirect_vld = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_info   <= '0;
      r_intr   <= 1'b0;
      r_mret   <= 1'b0;
      r_mepc   <= '0;
      r_target <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc_trap) begin
        r_info <= i_trap_info;
        r_intr <= i_trap_is_intr;
        r_mret <= 1'b0;
      end else if (w_acc_mret) begin
        r_intr <= 1'b0;
        r_mret <= 1'b1;
      end
      if (r_state == S_DRAIN && i_flush_done)
        r_mepc <= {i_mepc[XLEN-1:1], 1'b0};
      if (r_state == S_WR_STATUS)
        r_target <= r_mret ? r_mepc : w_trap_tgt;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed and randomized trap/mret sequences
// checked against a spec-level reference model.
module tb_trap_ctrl;
  import trap_pkg::*;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic            i_trap_vld;
  logic            o_trap_rdy;
  trapInfo_t       i_trap_info;
  logic            i_trap_is_intr;
  logic            i_mret_vld;
  logic            o_mret_rdy;
  logic            o_flush;
  logic            i_flush_done;
  logic            o_csr_we;
  csrIdx_t         o_csr_widx;
  logic [XLEN-1:0] o_csr_wdata;
  logic [XLEN-1:0] i_mtvec;
  logic [XLEN-1:0] i_mepc;
  logic [XLEN-1:0] i_mstatus;
  logic            o_redirect_vld;
  logic [XLEN-1:0] o_redirect_pc;
  logic            i_redirect_rdy;
  logic            o_busy;

  int n_chk;
  int n_fail;

  // stimulus for one event
  bit          s_mret;
  bit          s_intr;
  logic [15:0] s_cause;
  logic [63:0] s_epc, s_tval, s_mtvec, s_mepc, s_ms;
  int          s_dly, s_rdly;

  // expectations
  int          exp_n, exp_rd, exp_idle;
  logic [11:0] exp_idx[4];
  logic [63:0] exp_dat[4];
  logic [63:0] exp_tgt;

  // observations
  int          obs_n, obs_flush_n, obs_flush_cyc, obs_rd, obs_idle;
  logic [11:0] obs_idx[8];
  logic [63:0] obs_dat[8];
  int          obs_cyc[8];
  logic [63:0] obs_pc;
  bit          obs_pc_ok, obs_rdy0, obs_mret0, obs_mret_busy;

  trap_ctrl #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_trap_vld     (i_trap_vld),
    .o_trap_rdy     (o_trap_rdy),
    .i_trap_info    (i_trap_info),
    .i_trap_is_intr (i_trap_is_intr),
    .i_mret_vld     (i_mret_vld),
    .o_mret_rdy     (o_mret_rdy),
    .o_flush        (o_flush),
    .i_flush_done   (i_flush_done),
    .o_csr_we       (o_csr_we),
    .o_csr_widx     (o_csr_widx),
    .o_csr_wdata    (o_csr_wdata),
    .i_mtvec        (i_mtvec),
    .i_mepc         (i_mepc),
    .i_mstatus      (i_mstatus),
    .o_redirect_vld (o_redirect_vld),
    .o_redirect_pc  (o_redirect_pc),
    .i_redirect_rdy (i_redirect_rdy),
    .o_busy         (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: CSR writes, target and cycle timeline from the trap rules.
  function automatic void model();
    logic [63:0] base, ms;
    bit vec;
    base = s_mtvec & ~64'h3;
    ms   = (s_ms & ~64'h1888) | 64'h1800;
`ifdef TRAP_VECTORED_EN
    vec = s_intr && ((s_mtvec % 64'd4) == 64'd1);
`else
    vec = 1'b0;
`endif
    if (s_mret) begin
      exp_n      = 1;
      exp_idx[0] = 12'h300;
      exp_dat[0] = ms | 64'h80 | (64'(s_ms[7]) << 3);
      exp_tgt    = s_mepc & ~64'h1;
      exp_rd     = 4 + s_dly;
    end else begin
      exp_n      = 4;
      exp_idx[0] = 12'h341;
      exp_dat[0] = s_epc & ~64'h1;
      exp_idx[1] = 12'h342;
      exp_dat[1] = (64'(s_intr) << 63) | 64'(s_cause);
      exp_idx[2] = 12'h343;
      exp_dat[2] = s_intr ? 64'h0 : s_tval;
      exp_idx[3] = 12'h300;
      exp_dat[3] = ms | (64'(s_ms[3]) << 7);
      exp_tgt    = vec ? base + 64'(s_cause) * 64'd4 : base;
      exp_rd     = 7 + s_dly;
    end
    exp_idle = exp_rd + s_rdly + 1;
  endfunction

  // Offer one event at the current negedge (cycle 0) and record the timeline.
  task automatic run_event(input bit hold_mret);
    i_trap_info    = '{cause: s_cause, epc: s_epc, tval: s_tval};
    i_trap_is_intr = s_intr;
    i_mtvec        = s_mtvec;
    i_mepc         = s_mepc;
    i_mstatus      = s_ms;
    i_trap_vld     = !s_mret;
    i_mret_vld     = s_mret | hold_mret;
    i_flush_done   = (s_dly == 0);
    i_redirect_rdy = (s_rdly == 0);
    obs_n = 0; obs_flush_n = 0; obs_flush_cyc = -1;
    obs_rd = -1; obs_idle = -1; obs_pc = '0;
    obs_pc_ok = 1'b1; obs_mret_busy = 1'b0;
    #1;
    obs_rdy0  = s_mret ? o_mret_rdy : o_trap_rdy;
    obs_mret0 = o_mret_rdy;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      i_trap_vld   = 1'b0;
      i_mret_vld   = hold_mret;
      i_flush_done = (s_dly == 0) || (n >= 2 + s_dly);
      if (o_flush) begin
        obs_flush_n++;
        obs_flush_cyc = n;
      end
      if (o_csr_we && obs_n < 8) begin
        obs_idx[obs_n] = o_csr_widx;
        obs_dat[obs_n] = o_csr_wdata;
        obs_cyc[obs_n] = n;
        obs_n++;
      end
      if (o_redirect_vld) begin
        if (obs_rd < 0) begin
          obs_rd = n;
          obs_pc = o_redirect_pc;
        end else if (o_redirect_pc !== obs_pc) begin
          obs_pc_ok = 1'b0;
        end
      end
      if (o_busy && o_mret_rdy) obs_mret_busy = 1'b1;
      if (obs_rd >= 0) i_redirect_rdy = (n >= obs_rd + s_rdly);
      if (!o_busy) begin
        obs_idle = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    i_trap_vld = 1'b1;
    #1;
    n_chk++;
    if (o_trap_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_trap_rdy got %0b want 1", o_trap_rdy);
    end
    n_chk++;
    if (o_mret_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mret_rdy_vld got %0b want 0", o_mret_rdy);
    end
    i_trap_vld = 1'b0;
    #1;
    n_chk++;
    if (o_mret_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mret_rdy got %0b want 1", o_mret_rdy);
    end
    n_chk++;
    if ({o_flush, o_csr_we, o_redirect_vld, o_busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got %b want 0000",
               {o_flush, o_csr_we, o_redirect_vld, o_busy});
    end
    n_chk++;
    if ({o_csr_widx, o_csr_wdata, o_redirect_pc} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got %0h/%0h/%0h want 0",
               o_csr_widx, o_csr_wdata, o_redirect_pc);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Spec vectors: exception, interrupt, mret, stalled drain/redirect.
  task automatic test_directed();
    for (int t = 0; t < 4; t++) begin
      s_mret = 0; s_intr = 0; s_cause = 16'd2;
      s_epc = 64'h8000_0103; s_tval = 64'h13;
      s_mtvec = 64'h8000_1000; s_mepc = 64'h0; s_ms = 64'h8;
      s_dly = 0; s_rdly = 0;
      exp_n = 4; exp_rd = 7; exp_idle = 8;
      exp_idx[0] = 12'h341; exp_dat[0] = 64'h8000_0102;
      exp_idx[1] = 12'h342; exp_dat[1] = 64'h2;
      exp_idx[2] = 12'h343; exp_dat[2] = 64'h13;
      exp_idx[3] = 12'h300; exp_dat[3] = 64'h1880;
      exp_tgt = 64'h8000_1000;
      case (t)
        1: begin
          s_intr = 1; s_cause = 16'd7;
          s_epc = 64'h8000_0400; s_tval = 64'h55;
          s_mtvec = 64'h8000_1001;
          exp_dat[0] = 64'h8000_0400;
          exp_dat[1] = 64'h8000_0000_0000_0007;
          exp_dat[2] = 64'h0;
`ifdef TRAP_VECTORED_EN
          exp_tgt = 64'h8000_101C;
`else
          exp_tgt = 64'h8000_1000;
`endif
        end
        2: begin
          s_mret = 1; s_mepc = 64'h8000_0200; s_ms = 64'h1880;
          exp_n = 1; exp_rd = 4; exp_idle = 5;
          exp_idx[0] = 12'h300; exp_dat[0] = 64'h1888;
          exp_tgt = 64'h8000_0200;
        end
        3: begin
          s_dly = 5; s_rdly = 3;
          exp_rd = 12; exp_idle = 16;
        end
        default: ;
      endcase
      run_event(1'b0);
      n_chk++;
      if (obs_rdy0 !== 1'b1) begin
        n_fail++;
        $display("FAIL dir%0d_rdy got %0b want 1", t, obs_rdy0);
      end
      n_chk++;
      if (obs_flush_n !== 1 || obs_flush_cyc !== 1) begin
        n_fail++;
        $display("FAIL dir%0d_flush got %0d@%0d want 1@1",
                 t, obs_flush_n, obs_flush_cyc);
      end
      n_chk++;
      if (obs_n !== exp_n) begin
        n_fail++;
        $display("FAIL dir%0d_nwr got %0d want %0d", t, obs_n, exp_n);
      end
      for (int i = 0; i < exp_n; i++) begin
        n_chk++;
        if (obs_idx[i] !== exp_idx[i] || obs_dat[i] !== exp_dat[i] ||
            obs_cyc[i] !== exp_rd - exp_n + i) begin
          n_fail++;
          $display("FAIL dir%0d_wr%0d got %0h=%0h@%0d want %0h=%0h@%0d",
                   t, i, obs_idx[i], obs_dat[i], obs_cyc[i],
                   exp_idx[i], exp_dat[i], exp_rd - exp_n + i);
        end
      end
      n_chk++;
      if (obs_rd !== exp_rd || obs_pc !== exp_tgt) begin
        n_fail++;
        $display("FAIL dir%0d_redir got %0h@%0d want %0h@%0d",
                 t, obs_pc, obs_rd, exp_tgt, exp_rd);
      end
      n_chk++;
      if (obs_pc_ok !== 1'b1 || obs_idle !== exp_idle) begin
        n_fail++;
        $display("FAIL dir%0d_idle got stable=%0b idle@%0d want 1 idle@%0d",
                 t, obs_pc_ok, obs_idle, exp_idle);
      end
    end
  endtask

  task automatic test_back_to_back();
    s_mret = 0; s_intr = 0; s_cause = 16'd5;
    s_epc = 64'h8000_0800; s_tval = 64'h77;
    s_mtvec = 64'h8000_2000; s_ms = 64'h0;
    s_dly = 1; s_rdly = 1;
    model();
    run_event(1'b1);
    n_chk++;
    if (obs_rdy0 !== 1'b1 || obs_mret0 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_rdy got trap=%0b mret=%0b want 1/0",
               obs_rdy0, obs_mret0);
    end
    n_chk++;
    if (obs_n !== 4 || obs_rd !== exp_rd || obs_pc !== exp_tgt) begin
      n_fail++;
      $display("FAIL b2b_trap got n=%0d %0h@%0d want 4 %0h@%0d",
               obs_n, obs_pc, obs_rd, exp_tgt, exp_rd);
    end
    n_chk++;
    if (obs_mret_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_mret_busy got %0b want 0", obs_mret_busy);
    end
    s_mret = 1; s_mepc = 64'h8000_0301; s_ms = 64'h80;
    s_dly = 0; s_rdly = 0;
    model();
    run_event(1'b0);
    n_chk++;
    if (obs_rdy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_mret_rdy got %0b want 1", obs_rdy0);
    end
    n_chk++;
    if (obs_n !== 1 || obs_dat[0] !== exp_dat[0]) begin
      n_fail++;
      $display("FAIL b2b_mret_wr got n=%0d %0h want 1 %0h",
               obs_n, obs_dat[0], exp_dat[0]);
    end
    n_chk++;
    if (obs_rd !== 4 || obs_pc !== exp_tgt) begin
      n_fail++;
      $display("FAIL b2b_mret_redir got %0h@%0d want %0h@4",
               obs_pc, obs_rd, exp_tgt);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      s_mret  = ($urandom_range(0, 3) == 0);
      s_intr  = $urandom_range(0, 1);
      s_cause = 16'($urandom);
      s_epc   = {$urandom, $urandom};
      s_tval  = {$urandom, $urandom};
      s_mtvec = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) s_mtvec[1:0] = 2'b01;
      s_mepc  = {$urandom, $urandom};
      s_ms    = {$urandom, $urandom};
      s_dly   = $urandom_range(0, 4);
      s_rdly  = $urandom_range(0, 3);
      model();
      run_event(1'b0);
      n_chk++;
      if (obs_n !== exp_n || obs_flush_n !== 1) begin
        n_fail++;
        $display("FAIL rnd%0d_count got wr=%0d fl=%0d want %0d/1",
                 k, obs_n, obs_flush_n, exp_n);
      end
      for (int i = 0; i < exp_n; i++) begin
        n_chk++;
        if (obs_idx[i] !== exp_idx[i] || obs_dat[i] !== exp_dat[i] ||
            obs_cyc[i] !== exp_rd - exp_n + i) begin
          n_fail++;
          $display("FAIL rnd%0d_wr%0d got %0h=%0h@%0d want %0h=%0h@%0d",
                   k, i, obs_idx[i], obs_dat[i], obs_cyc[i],
                   exp_idx[i], exp_dat[i], exp_rd - exp_n + i);
        end
      end
      n_chk++;
      if (obs_rd !== exp_rd || obs_pc !== exp_tgt || !obs_pc_ok) begin
        n_fail++;
        $display("FAIL rnd%0d_redir got %0h@%0d want %0h@%0d",
                 k, obs_pc, obs_rd, exp_tgt, exp_rd);
      end
      n_chk++;
      if (obs_idle !== exp_idle) begin
        n_fail++;
        $display("FAIL rnd%0d_idle got %0d want %0d", k, obs_idle, exp_idle);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    s_mret = 0; s_intr = 0; s_cause = 16'd4;
    s_epc = 64'h8000_0a00; s_tval = 64'h99;
    s_mtvec = 64'h8000_3000; s_ms = 64'h8;
    i_trap_info    = '{cause: s_cause, epc: s_epc, tval: s_tval};
    i_trap_is_intr = 1'b0;
    i_mtvec = s_mtvec; i_mstatus = s_ms;
    i_flush_done = 1'b1; i_redirect_rdy = 1'b1;
    i_trap_vld = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      i_trap_vld = 1'b0;
    end
    n_chk++;
    if (o_csr_we !== 1'b1 || o_csr_widx !== 12'h343) begin
      n_fail++;
      $display("FAIL rstmid_tval got we=%0b idx=%0h want 1 343",
               o_csr_we, o_csr_widx);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if ({o_flush, o_csr_we, o_redirect_vld, o_busy} !== 4'b0 ||
        {o_csr_widx, o_csr_wdata, o_redirect_pc} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outs got %b %0h %0h %0h want 0",
               {o_flush, o_csr_we, o_redirect_vld, o_busy},
               o_csr_widx, o_csr_wdata, o_redirect_pc);
    end
    n_chk++;
    if (o_trap_rdy !== 1'b1 || o_mret_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_rdy got %0b/%0b want 1/1", o_trap_rdy, o_mret_rdy);
    end
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (o_csr_we || o_redirect_vld || o_busy) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rstmid_quiet got %0d active cycles want 0", bad);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    i_trap_vld = 1'b0;
    i_mret_vld = 1'b0;
    i_trap_info = '0;
    i_trap_is_intr = 1'b0;
    i_flush_done = 1'b0;
    i_redirect_rdy = 1'b0;
    i_mtvec = '0;
    i_mepc = '0;
    i_mstatus = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
